// File: rtl/cam_ctrl_pkg.sv
// Shared op codes, response status codes and controller FSM states for the CAM
// command front-end.
package cam_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_SEARCH = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_CLEAR  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        RSP_OK   = 2'd0,
        RSP_MISS = 2'd1,
        RSP_DUP  = 2'd2,
        RSP_FULL = 2'd3
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_DECIDE,
        S_WRITE,
        S_RESP
    } state_t;

endpackage

// File: rtl/cam_free_finder.sv
// Combinational lowest-free-slot finder over the occupancy bitmap.
module cam_free_finder #(
    parameter int ADDR_WIDTH = 2
) (
    input  logic [2**ADDR_WIDTH-1:0] valid_map,
    output logic                     free_valid,
    output logic [ADDR_WIDTH-1:0]    free_addr
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;

    // Scan from the top down so the last assignment is the lowest free index.
    always_comb begin
        free_valid = 1'b0;
        free_addr  = '0;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (!valid_map[i-1]) begin
                free_valid = 1'b1;
                free_addr  = ADDR_WIDTH'(i - 1);
            end
        end
    end

endmodule

// File: rtl/cam_cmd_ctrl.sv
// INSERT/SEARCH/DELETE/CLEAR front-end for a CAM with an occupancy bitmap.
// Optional occupancy count output enabled by defining CAM_CTRL_COUNT_EN.
module cam_cmd_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int CAM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_status,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  cam_write_enable,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_din,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr
`ifdef CAM_CTRL_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]   occupancy
`endif
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int CW    = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1;

    state_t                r_state;
    state_t                w_next;
    op_t                   r_op;
    logic [CW-1:0]         r_lat_cnt;
    logic [DEPTH-1:0]      r_valid;
    status_t               r_status;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  w_hit;
    logic                  w_free_valid;
    logic [ADDR_WIDTH-1:0] w_free_addr;

    cam_free_finder #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_free_finder (
        .valid_map  (r_valid),
        .free_valid (w_free_valid),
        .free_addr  (w_free_addr)
    );

    // Stale CAM contents are masked off by the bitmap.
    assign w_hit = cam_match & r_valid[cam_match_addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cmd_valid) w_next = (cmd_op == OP_CLEAR) ? S_DECIDE : S_LOOKUP;
            S_LOOKUP: if (r_lat_cnt == '0) w_next = S_DECIDE;
            S_DECIDE: w_next = (r_op == OP_INSERT && !w_hit && w_free_valid) ? S_WRITE : S_RESP;
            S_WRITE:  w_next = S_RESP;
            S_RESP:   if (rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op      <= OP_SEARCH;
            r_lat_cnt <= '0;
            r_valid   <= '0;
            r_status  <= RSP_OK;
            r_addr    <= '0;
            r_wr_addr <= '0;
            r_din     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (cmd_valid) begin
                    r_op      <= op_t'(cmd_op);
                    r_din     <= cmd_data;
                    r_lat_cnt <= CW'(CAM_LAT - 1);
                end
                S_LOOKUP: if (r_lat_cnt != '0) r_lat_cnt <= r_lat_cnt - CW'(1);
                S_DECIDE: begin
                    r_status <= RSP_OK;
                    r_addr   <= '0;
                    case (r_op)
                        OP_SEARCH, OP_DELETE: begin
                            if (w_hit) begin
                                r_addr <= cam_match_addr;
                                if (r_op == OP_DELETE) r_valid[cam_match_addr] <= 1'b0;
                            end else begin
                                r_status <= RSP_MISS;
                            end
                        end
                        OP_INSERT: begin
                            if (w_hit) begin
                                r_status <= RSP_DUP;
                                r_addr   <= cam_match_addr;
                            end else if (!w_free_valid) begin
                                r_status <= RSP_FULL;
                            end else begin
                                r_addr    <= w_free_addr;
                                r_wr_addr <= w_free_addr;
                            end
                        end
                        default: r_valid <= '0;
                    endcase
                end
                S_WRITE: r_valid[r_wr_addr] <= 1'b1;
                default: ;
            endcase
        end
    end

    assign cmd_ready        = (r_state == S_IDLE);
    assign rsp_valid        = (r_state == S_RESP);
    assign cam_write_enable = (r_state == S_WRITE);
    assign cam_write_addr   = r_wr_addr;
    assign cam_din          = r_din;
    assign rsp_status       = r_status;
    assign rsp_addr         = r_addr;

`ifdef CAM_CTRL_COUNT_EN
    logic [ADDR_WIDTH:0] r_occ;
    logic [ADDR_WIDTH:0] w_pop;

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < DEPTH; i++) w_pop = w_pop + (ADDR_WIDTH+1)'(r_valid[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_occ <= '0;
        else      r_occ <= w_pop;
    end

    assign occupancy = r_occ;
`endif

endmodule

// File: tb/tb_cam_cmd_ctrl.sv
// Self-checking bench for cam_cmd_ctrl: behavioural CAM plus a slot-table reference model.
module tb_cam_cmd_ctrl;
    import cam_ctrl_pkg::*;

    localparam int DW      = 4;
    localparam int AW      = 2;
    localparam int DEPTH   = 2**AW;
    localparam int CAM_LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_status;
    logic [AW-1:0] rsp_addr;
    logic          cam_write_enable;
    logic [AW-1:0] cam_write_addr;
    logic [DW-1:0] cam_din;
    logic          cam_match;
    logic [AW-1:0] cam_match_addr;
`ifdef CAM_CTRL_COUNT_EN
    logic [AW:0]   occupancy;
`endif

    always #5 clk = ~clk;

    cam_cmd_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CAM_LAT    (CAM_LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_data         (cmd_data),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_status       (rsp_status),
        .rsp_addr         (rsp_addr),
        .cam_write_enable (cam_write_enable),
        .cam_write_addr   (cam_write_addr),
        .cam_din          (cam_din),
        .cam_match        (cam_match),
        .cam_match_addr   (cam_match_addr)
`ifdef CAM_CTRL_COUNT_EN
        ,
        .occupancy        (occupancy)
`endif
    );

    // Behavioural CAM: lowest matching written entry, CAM_LAT cycles after cam_din.
    logic [DW-1:0] cam_mem [DEPTH] = '{default: '0};
    logic          cam_wr  [DEPTH] = '{default: 1'b0};
    logic          m_pipe  [CAM_LAT] = '{default: 1'b0};
    logic [AW-1:0] a_pipe  [CAM_LAT] = '{default: '0};

    always @(posedge clk) begin
        logic          m;
        logic [AW-1:0] a;
        m = 1'b0;
        a = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cam_wr[i] && cam_mem[i] == cam_din) begin
                m = 1'b1;
                a = AW'(i);
            end
        end
        m_pipe[0] <= m;
        a_pipe[0] <= a;
        for (int s = 1; s < CAM_LAT; s++) begin
            m_pipe[s] <= m_pipe[s-1];
            a_pipe[s] <= a_pipe[s-1];
        end
        if (cam_write_enable) begin
            cam_mem[cam_write_addr] <= cam_din;
            cam_wr[cam_write_addr]  <= 1'b1;
        end
    end

    assign cam_match      = m_pipe[CAM_LAT-1];
    assign cam_match_addr = a_pipe[CAM_LAT-1];

    // Edge monitor: write strobes and response handshakes actually taken.
    int unsigned   wr_cnt  = 0;
    int unsigned   rsp_cnt = 0;
    logic [AW-1:0] last_wa = '0;
    logic [DW-1:0] last_wd = '0;

    always @(posedge clk) begin
        if (rst && cam_write_enable) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= cam_write_addr;
            last_wd <= cam_din;
        end
        if (rst && rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
    end

    // Reference model: which slots hold which live keys.
    logic          ref_v [DEPTH] = '{default: 1'b0};
    logic [DW-1:0] ref_k [DEPTH] = '{default: '0};

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [DW-1:0] key,
                         output logic [1:0] st, output logic [AW-1:0] ad, output logic wr);
        int found = -1;
        int free  = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (ref_v[i] && ref_k[i] == key) found = i;
            if (!ref_v[i] && free < 0) free = i;
        end
        st = RSP_OK;
        ad = '0;
        wr = 1'b0;
        case (op)
            OP_SEARCH: if (found >= 0) ad = AW'(found); else st = RSP_MISS;
            OP_INSERT: begin
                if (found >= 0) begin
                    st = RSP_DUP;
                    ad = AW'(found);
                end else if (free < 0) begin
                    st = RSP_FULL;
                end else begin
                    ad = AW'(free);
                    wr = 1'b1;
                    ref_v[free] = 1'b1;
                    ref_k[free] = key;
                end
            end
            OP_DELETE: begin
                if (found >= 0) begin
                    ad = AW'(found);
                    ref_v[found] = 1'b0;
                end else st = RSP_MISS;
            end
            default: for (int i = 0; i < DEPTH; i++) ref_v[i] = 1'b0;
        endcase
    endtask

    function automatic int unsigned ref_count();
        int unsigned c = 0;
        for (int i = 0; i < DEPTH; i++) c += ref_v[i] ? 1 : 0;
        return c;
    endfunction

    // Issue one command (called #1 after a rising edge), hold rsp_ready low for 'hold' cycles.
    task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] key, input int unsigned hold);
        logic [1:0]    es;
        logic [AW-1:0] ea;
        logic          ew;
        int unsigned   elat;
        int unsigned   e;
        int unsigned   wr0;
        int unsigned   rsp0;
        model(op, key, es, ea, ew);
        elat = (op == OP_CLEAR) ? 1 : (ew ? CAM_LAT + 2 : CAM_LAT + 1);
        check("cmd_ready_idle", cmd_ready, 1);
        wr0  = wr_cnt;
        rsp0 = rsp_cnt;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = key;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = DW'($urandom);
        e = 0;
        while (!rsp_valid && e < 50) begin
            check("cmd_ready_busy", cmd_ready, 0);
            @(posedge clk); #1;
            e++;
        end
        check("latency", e, elat);
        check("rsp_status", rsp_status, es);
        check("rsp_addr", rsp_addr, ea);
        check("cmd_ready_resp", cmd_ready, 0);
        if (op != OP_CLEAR) check("cam_din_held", cam_din, key);
        for (int unsigned h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_status", rsp_status, es);
            check("hold_addr", rsp_addr, ea);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_count", rsp_cnt - rsp0, 1);
        check("rsp_valid_drop", rsp_valid, 0);
        check("write_count", wr_cnt - wr0, 32'(ew));
        if (ew) begin
            check("write_addr", last_wa, ea);
            check("write_data", last_wd, key);
        end
`ifdef CAM_CTRL_COUNT_EN
        check("occupancy", occupancy, ref_count());
`endif
    endtask

    initial begin
        int unsigned e;
        int unsigned wr0;
        int unsigned rsp0;
        int unsigned r;
        logic [1:0]  op;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_rsp_addr", rsp_addr, 0);
        check("rst_wr_en", cam_write_enable, 0);
        check("rst_wr_addr", cam_write_addr, 0);
        check("rst_cam_din", cam_din, 0);
`ifdef CAM_CTRL_COUNT_EN
        check("rst_occupancy", occupancy, 0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;

        // Insert/search, then duplicate insert.
        run_cmd(OP_INSERT, 4'hA, 0);
        run_cmd(OP_SEARCH, 4'hA, 0);
        run_cmd(OP_INSERT, 4'hA, 0);

        // Fill, full, dup on a full table.
        run_cmd(OP_CLEAR, 4'h0, 0);
        for (int k = 1; k <= 4; k++) run_cmd(OP_INSERT, DW'(k), 0);
        run_cmd(OP_INSERT, 4'h5, 0);
        run_cmd(OP_INSERT, 4'h3, 0);

        // Delete, miss on stale data, reuse of freed slot.
        run_cmd(OP_DELETE, 4'h2, 0);
        run_cmd(OP_SEARCH, 4'h2, 0);
        run_cmd(OP_INSERT, 4'h7, 0);

        // Backpressure on the response.
        run_cmd(OP_SEARCH, 4'h3, 5);

        // Reset asserted during the write cycle.
        run_cmd(OP_CLEAR, 4'h0, 0);
        wr0  = wr_cnt;
        rsp0 = rsp_cnt;
        cmd_valid = 1'b1;
        cmd_op    = OP_INSERT;
        cmd_data  = 4'h9;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        e = 0;
        while (!cam_write_enable && e < 20) begin
            @(posedge clk); #1;
            e++;
        end
        check("reach_write", cam_write_enable, 1);
        rst = 1'b0;
        #1;
        check("midrst_wr_en", cam_write_enable, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < DEPTH; i++) ref_v[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_no_strobe", wr_cnt - wr0, 0);
        check("midrst_no_rsp", rsp_cnt - rsp0, 0);
        run_cmd(OP_SEARCH, 4'h9, 0);

        // CLEAR drops every live key.
        run_cmd(OP_INSERT, 4'h1, 0);
        run_cmd(OP_INSERT, 4'h2, 0);
        run_cmd(OP_CLEAR, 4'h0, 0);
        run_cmd(OP_SEARCH, 4'h1, 0);
        run_cmd(OP_SEARCH, 4'h2, 0);

        // Randomized command mix over a small key space.
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 19);
            if (r < 8)       op = OP_INSERT;
            else if (r < 13) op = OP_SEARCH;
            else if (r < 18) op = OP_DELETE;
            else             op = OP_CLEAR;
            run_cmd(op, DW'($urandom_range(0, 6)),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
